// File: rtl/spread_stats.sv
// spread_stats: samples the registered spread one cycle after each qualified
// match strobe and maintains last/min/max, a moving-window average, a
// saturating sample count and a wide-spread alarm.
module spread_stats #(
    parameter int WIDTH    = 8,
    parameter int WIN_LOG2 = 3,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             match_signal,
    input  logic             enable_count,
    input  logic [WIDTH-1:0] spread,
    input  logic             clear,
    input  logic [WIDTH-1:0] alarm_thresh,
    output logic [WIDTH-1:0] last_spread,
    output logic [WIDTH-1:0] min_spread,
    output logic [WIDTH-1:0] max_spread,
    output logic [WIDTH-1:0] avg_spread,
    output logic             avg_valid,
    output logic [CNT_W-1:0] sample_count,
    output logic             stat_update,
    output logic             alarm
);

    localparam int unsigned DEPTH = 2 ** WIN_LOG2;
    localparam int          SUM_W = WIDTH + WIN_LOG2;
    localparam logic [WIN_LOG2:0] FILL_FULL = (WIN_LOG2 + 1)'(DEPTH);

    logic                pend;
    logic [WIDTH-1:0]    win [DEPTH];
    logic [SUM_W-1:0]    sum;
    logic [WIN_LOG2-1:0] wr_ptr;
    logic [WIN_LOG2:0]   fill;

    logic                take;
    logic [SUM_W-1:0]    sum_next;
    logic [WIN_LOG2:0]   fill_next;
    logic [WIDTH-1:0]    min_next;
    logic [WIDTH-1:0]    max_next;

    // A pending sample is discarded when clear arrives in the same cycle.
    assign take      = pend && !clear;
    assign avg_valid = (fill == FILL_FULL);
    assign alarm     = avg_valid && (avg_spread > alarm_thresh);

    // Next window sum, fill level and extremes for the sample being taken.
    always_comb begin
        sum_next  = sum + SUM_W'(spread) - SUM_W'(win[wr_ptr]);
        fill_next = (fill == FILL_FULL) ? fill : fill + 1'b1;
        if (sample_count == '0) begin
            min_next = spread;
            max_next = spread;
        end else begin
            min_next = (spread < min_spread) ? spread : min_spread;
            max_next = (spread > max_spread) ? spread : max_spread;
        end
    end

    // Strobe alignment, window buffer and all registered statistics.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend         <= 1'b0;
            sum          <= '0;
            wr_ptr       <= '0;
            fill         <= '0;
            last_spread  <= '0;
            min_spread   <= '0;
            max_spread   <= '0;
            avg_spread   <= '0;
            sample_count <= '0;
            stat_update  <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) win[i] <= '0;
        end else begin
            pend        <= match_signal && enable_count;
            stat_update <= take;
            if (clear) begin
                sum          <= '0;
                wr_ptr       <= '0;
                fill         <= '0;
                last_spread  <= '0;
                min_spread   <= '0;
                max_spread   <= '0;
                avg_spread   <= '0;
                sample_count <= '0;
                for (int unsigned i = 0; i < DEPTH; i++) win[i] <= '0;
            end else if (take) begin
                last_spread <= spread;
                min_spread  <= min_next;
                max_spread  <= max_next;
                if (sample_count != '1) sample_count <= sample_count + 1'b1;
                sum         <= sum_next;
                win[wr_ptr] <= spread;
                wr_ptr      <= wr_ptr + 1'b1;
                fill        <= fill_next;
                // Evicted entries read as zero until the window first fills,
                // since the buffer is cleared alongside the sum.
                avg_spread  <= (fill_next == FILL_FULL) ? sum_next[SUM_W-1:WIN_LOG2] : '0;
            end
        end
    end

endmodule
